// File: rtl/ctrl_sequencer_if.sv
// Control strobe bundle between the hardwired sequencer and the single-bus datapath.
// Latency: none, wires only.
// Backpressure: none on the strobes; the optional mem_ready on the sequencer stretches memory steps.
interface ctrl_sequencer_if #(
    parameter int OPC_W = 5,
    parameter int T_W   = 3
);
    // Opcode field IR[31:27] from the datapath
    logic [OPC_W-1:0] opcode;

    // Bus drivers
    logic PCout, Zlowout, MDRout, BAout, Rout, Cout;
    // Register loads
    logic PCin, IRin, MARin, MDRin, Yin, Zin, Rin;
    // ALU selects
    logic IncPC, ADD;
    // Register-field selects
    logic Gra, Grb, Grc;
    // Memory strobes
    logic Read, Write;
    // Status and debug
    logic           run;
    logic           illegal;
    logic [T_W-1:0] t_step;

    // Sequencer side: reads the opcode, drives every strobe
    modport master (
        input  opcode,
        output PCout, Zlowout, MDRout, BAout, Rout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
        output IncPC, ADD, Gra, Grb, Grc, Read, Write,
        output run, illegal, t_step
    );

    // Datapath side: supplies the opcode, consumes the strobes
    modport slave (
        output opcode,
        input  PCout, Zlowout, MDRout, BAout, Rout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
        input  IncPC, ADD, Gra, Grb, Grc, Read, Write,
        input  run, illegal, t_step
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired T-step control unit: fetch T0-T2, then ld/ldi/st/addi/nop/halt execute steps.
// Latency: Moore strobes straight from the state register; ld 8, ldi 6, st 8, addi 6, nop 3 cycles.
// Backpressure: with CTRL_MEM_WAIT_EN defined, T1/LD6/ST7 hold until mem_ready=1; otherwise none.
module ctrl_sequencer #(
    parameter int OPC_W = 5,
    parameter int T_W   = 3
) (
    input  logic clk,
    input  logic reset,
`ifdef CTRL_MEM_WAIT_EN
    input  logic mem_ready,
`endif
    ctrl_sequencer_if.master bus
);

    localparam logic [4:0] S_T0   = 5'd0;
    localparam logic [4:0] S_T1   = 5'd1;
    localparam logic [4:0] S_T2   = 5'd2;
    localparam logic [4:0] S_LD3  = 5'd3;
    localparam logic [4:0] S_LD4  = 5'd4;
    localparam logic [4:0] S_LD5  = 5'd5;
    localparam logic [4:0] S_LD6  = 5'd6;
    localparam logic [4:0] S_LD7  = 5'd7;
    localparam logic [4:0] S_LDI3 = 5'd8;
    localparam logic [4:0] S_LDI4 = 5'd9;
    localparam logic [4:0] S_LDI5 = 5'd10;
    localparam logic [4:0] S_ST3  = 5'd11;
    localparam logic [4:0] S_ST4  = 5'd12;
    localparam logic [4:0] S_ST5  = 5'd13;
    localparam logic [4:0] S_ST6  = 5'd14;
    localparam logic [4:0] S_ST7  = 5'd15;
    localparam logic [4:0] S_ADI3 = 5'd16;
    localparam logic [4:0] S_ADI4 = 5'd17;
    localparam logic [4:0] S_ADI5 = 5'd18;
    localparam logic [4:0] S_HALT = 5'd19;

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11010);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

    typedef struct packed {
        logic pc_out, zlow_out, mdr_out, ba_out, r_out, c_out;
        logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, r_in;
        logic inc_pc, add, gra, grb, grc, read, write;
    } strobe_t;

    logic [4:0] state;
    logic [4:0] state_nxt;
    logic       illegal_q;
    logic       decode_bad;
    logic       mem_done;
    strobe_t    str;
    strobe_t    str_out;
    logic [2:0] t_idx;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    // Next-state: fixed step chain per instruction, opcode decode on leaving T2
    always_comb begin
        state_nxt  = state;
        decode_bad = 1'b0;
        case (state)
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = mem_done ? S_T2 : S_T1;
            S_T2: begin
                case (bus.opcode)
                    OP_LD:   state_nxt = S_LD3;
                    OP_LDI:  state_nxt = S_LDI3;
                    OP_ST:   state_nxt = S_ST3;
                    OP_ADDI: state_nxt = S_ADI3;
                    OP_NOP:  state_nxt = S_T0;
                    OP_HALT: state_nxt = S_HALT;
                    default: begin
                        state_nxt  = S_HALT;
                        decode_bad = 1'b1;
                    end
                endcase
            end
            S_LD3:  state_nxt = S_LD4;
            S_LD4:  state_nxt = S_LD5;
            S_LD5:  state_nxt = S_LD6;
            S_LD6:  state_nxt = mem_done ? S_LD7 : S_LD6;
            S_LD7:  state_nxt = S_T0;
            S_LDI3: state_nxt = S_LDI4;
            S_LDI4: state_nxt = S_LDI5;
            S_LDI5: state_nxt = S_T0;
            S_ST3:  state_nxt = S_ST4;
            S_ST4:  state_nxt = S_ST5;
            S_ST5:  state_nxt = S_ST6;
            S_ST6:  state_nxt = S_ST7;
            S_ST7:  state_nxt = mem_done ? S_T0 : S_ST7;
            S_ADI3: state_nxt = S_ADI4;
            S_ADI4: state_nxt = S_ADI5;
            S_ADI5: state_nxt = S_T0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_T0;
        endcase
    end

    // State and sticky illegal flag; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_T0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_T2 && decode_bad) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Moore strobe decode; BAout (not Rout) forms base addresses so R0 reads as zero
    always_comb begin
        str   = '0;
        t_idx = 3'd0;
        case (state)
            S_T0:   begin t_idx = 3'd0; str.pc_out = 1'b1; str.mar_in = 1'b1; str.inc_pc = 1'b1; str.z_in = 1'b1; end
            S_T1:   begin t_idx = 3'd1; str.zlow_out = 1'b1; str.pc_in = 1'b1; str.read = 1'b1; str.mdr_in = 1'b1; end
            S_T2:   begin t_idx = 3'd2; str.mdr_out = 1'b1; str.ir_in = 1'b1; end
            S_LD3, S_LDI3, S_ST3: begin
                t_idx = 3'd3; str.grb = 1'b1; str.ba_out = 1'b1; str.y_in = 1'b1;
            end
            S_ADI3: begin t_idx = 3'd3; str.grb = 1'b1; str.r_out = 1'b1; str.y_in = 1'b1; end
            S_LD4, S_LDI4, S_ST4, S_ADI4: begin
                t_idx = 3'd4; str.c_out = 1'b1; str.add = 1'b1; str.z_in = 1'b1;
            end
            S_LD5, S_ST5: begin t_idx = 3'd5; str.zlow_out = 1'b1; str.mar_in = 1'b1; end
            S_LDI5, S_ADI5: begin
                t_idx = 3'd5; str.zlow_out = 1'b1; str.gra = 1'b1; str.r_in = 1'b1;
            end
            S_LD6:  begin t_idx = 3'd6; str.read = 1'b1; str.mdr_in = 1'b1; end
            S_ST6:  begin t_idx = 3'd6; str.gra = 1'b1; str.r_out = 1'b1; str.mdr_in = 1'b1; end
            S_LD7:  begin t_idx = 3'd7; str.mdr_out = 1'b1; str.gra = 1'b1; str.r_in = 1'b1; end
            S_ST7:  begin t_idx = 3'd7; str.write = 1'b1; end
            S_HALT: begin t_idx = 3'd7; end
            default: begin t_idx = 3'd0; end
        endcase
    end

    // All strobes are forced low while reset is held
    always_comb begin
        str_out = reset ? '0 : str;
    end

    assign bus.PCout   = str_out.pc_out;
    assign bus.Zlowout = str_out.zlow_out;
    assign bus.MDRout  = str_out.mdr_out;
    assign bus.BAout   = str_out.ba_out;
    assign bus.Rout    = str_out.r_out;
    assign bus.Cout    = str_out.c_out;
    assign bus.PCin    = str_out.pc_in;
    assign bus.IRin    = str_out.ir_in;
    assign bus.MARin   = str_out.mar_in;
    assign bus.MDRin   = str_out.mdr_in;
    assign bus.Yin     = str_out.y_in;
    assign bus.Zin     = str_out.z_in;
    assign bus.Rin     = str_out.r_in;
    assign bus.IncPC   = str_out.inc_pc;
    assign bus.ADD     = str_out.add;
    assign bus.Gra     = str_out.gra;
    assign bus.Grb     = str_out.grb;
    assign bus.Grc     = str_out.grc;
    assign bus.Read    = str_out.read;
    assign bus.Write   = str_out.write;
    assign bus.run     = (state != S_HALT);
    assign bus.illegal = illegal_q;
    assign bus.t_step  = T_W'(t_idx);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: random instruction stream against a per-opcode strobe table.
// Latency: checks every cycle at negedge+1.
// Backpressure: with CTRL_MEM_WAIT_EN defined, random mem_ready stalls on memory steps.
module tb_ctrl_sequencer;

    logic clk = 1'b0;
    logic reset;
`ifdef CTRL_MEM_WAIT_EN
    logic mem_ready = 1'b1;
`endif

    ctrl_sequencer_if #(.OPC_W(5), .T_W(3)) bus ();

    ctrl_sequencer #(.OPC_W(5), .T_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Strobe bit positions in the bench's 20-bit observation word
    localparam logic [19:0] M_PCOUT   = 20'h00001;
    localparam logic [19:0] M_ZLOWOUT = 20'h00002;
    localparam logic [19:0] M_MDROUT  = 20'h00004;
    localparam logic [19:0] M_BAOUT   = 20'h00008;
    localparam logic [19:0] M_ROUT    = 20'h00010;
    localparam logic [19:0] M_COUT    = 20'h00020;
    localparam logic [19:0] M_PCIN    = 20'h00040;
    localparam logic [19:0] M_IRIN    = 20'h00080;
    localparam logic [19:0] M_MARIN   = 20'h00100;
    localparam logic [19:0] M_MDRIN   = 20'h00200;
    localparam logic [19:0] M_YIN     = 20'h00400;
    localparam logic [19:0] M_ZIN     = 20'h00800;
    localparam logic [19:0] M_RIN     = 20'h01000;
    localparam logic [19:0] M_INCPC   = 20'h02000;
    localparam logic [19:0] M_ADD     = 20'h04000;
    localparam logic [19:0] M_GRA     = 20'h08000;
    localparam logic [19:0] M_GRB     = 20'h10000;
    localparam logic [19:0] M_GRC     = 20'h20000;
    localparam logic [19:0] M_READ    = 20'h40000;
    localparam logic [19:0] M_WRITE   = 20'h80000;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp_q[$];
    bit          exp_halt;
    bit          exp_illegal;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [19:0] observed();
        logic [19:0] v;
        v = '0;
        if (bus.PCout)   v |= M_PCOUT;
        if (bus.Zlowout) v |= M_ZLOWOUT;
        if (bus.MDRout)  v |= M_MDROUT;
        if (bus.BAout)   v |= M_BAOUT;
        if (bus.Rout)    v |= M_ROUT;
        if (bus.Cout)    v |= M_COUT;
        if (bus.PCin)    v |= M_PCIN;
        if (bus.IRin)    v |= M_IRIN;
        if (bus.MARin)   v |= M_MARIN;
        if (bus.MDRin)   v |= M_MDRIN;
        if (bus.Yin)     v |= M_YIN;
        if (bus.Zin)     v |= M_ZIN;
        if (bus.Rin)     v |= M_RIN;
        if (bus.IncPC)   v |= M_INCPC;
        if (bus.ADD)     v |= M_ADD;
        if (bus.Gra)     v |= M_GRA;
        if (bus.Grb)     v |= M_GRB;
        if (bus.Grc)     v |= M_GRC;
        if (bus.Read)    v |= M_READ;
        if (bus.Write)   v |= M_WRITE;
        return v;
    endfunction

    // Reference: the listed strobe set for each step of an instruction, fetch first
    task automatic build_seq(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        exp_q.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
        exp_q.push_back(M_MDROUT | M_IRIN);
        exp_halt    = 1'b0;
        exp_illegal = 1'b0;
        case (op)
            5'b00000: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_ZLOWOUT | M_MARIN);
                exp_q.push_back(M_READ | M_MDRIN);
                exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
            end
            5'b00001: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'b00010: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_ZLOWOUT | M_MARIN);
                exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
                exp_q.push_back(M_WRITE);
            end
            5'b01100: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'b11010: ;
            5'b11011: exp_halt = 1'b1;
            default: begin
                exp_halt    = 1'b1;
                exp_illegal = 1'b1;
            end
        endcase
    endtask

    task automatic advance();
        @(negedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [19:0] strobes,
                               input logic [2:0] tstep, input logic run, input logic ill);
        chk({tag, ".strobes"}, 32'(observed()), 32'(strobes));
        chk({tag, ".t_step"},  32'(bus.t_step), 32'(tstep));
        chk({tag, ".run"},     32'(bus.run), 32'(run));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    endtask

    // Hold reset for n cycles, expect quiet strobes and T0, then release into T0
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            advance();
            check_cycle($sformatf("rst%0d", i), 20'h0, 3'd0, 1'b1, 1'b0);
        end
        reset = 1'b0;
        #1;
    endtask

    // Run one instruction from T0; abort_at >= 0 asserts reset after that step
    task automatic run_instr(input logic [4:0] op, input int abort_at);
        build_seq(op);
        bus.opcode = op;
        for (int k = 0; k < exp_q.size(); k++) begin
`ifdef CTRL_MEM_WAIT_EN
            if ((exp_q[k] & (M_READ | M_WRITE)) != 20'h0) begin
                int w;
                w = $urandom_range(0, 2);
                for (int j = 0; j < w; j++) begin
                    mem_ready = 1'b0;
                    check_cycle($sformatf("op%02h.s%0d.w%0d", op, k, j), exp_q[k], 3'(k), 1'b1, 1'b0);
                    advance();
                end
                mem_ready = 1'b1;
            end
`endif
            check_cycle($sformatf("op%02h.s%0d", op, k), exp_q[k], 3'(k), 1'b1, 1'b0);
            if (k == abort_at) begin
                do_reset(1);
                return;
            end
            advance();
        end
        if (exp_halt) begin
            for (int h = 0; h < 20; h++) begin
                check_cycle($sformatf("op%02h.halt%0d", op, h), 20'h0, 3'd7, 1'b0, exp_illegal);
                bus.opcode = 5'($urandom);
                advance();
            end
            do_reset(2);
        end
    endtask

    initial begin
        logic [4:0] op;
        int         r;
        reset      = 1'b1;
        bus.opcode = 5'b11010;
        do_reset(2);

        // Directed: each instruction class, then abort of ld at LD5
        run_instr(5'b00000, -1);
        run_instr(5'b00001, -1);
        run_instr(5'b00010, -1);
        run_instr(5'b01100, -1);
        run_instr(5'b11010, -1);
        run_instr(5'b00000, 5);
        run_instr(5'b11011, -1);
        run_instr(5'b10101, -1);

        // Random instruction stream with occasional mid-instruction resets
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    op = 5'b00000;
                2, 3:    op = 5'b00001;
                4, 5:    op = 5'b00010;
                6, 7:    op = 5'b01100;
                8:       op = 5'b11010;
                9:       op = 5'b11011;
                default: begin
                    op = 5'($urandom);
                    while (op == 5'b00000 || op == 5'b00001 || op == 5'b00010 ||
                           op == 5'b01100 || op == 5'b11010 || op == 5'b11011) begin
                        op = 5'($urandom);
                    end
                end
            endcase
            if (r <= 7 && $urandom_range(0, 5) == 0) begin
                run_instr(op, $urandom_range(0, 5));
            end else begin
                run_instr(op, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
